key_burst_gen: RTL and testbench
================================

KEY_BURST_GEN -- requirements
Module: key_burst_gen

Interface
REQ-001 SHALL have parameter C_KEY_WIDTH, 24, total key width (17..48).
REQ-002 SHALL have parameter C_PREFIX_WIDTH, 16, width of the fixed upper key field (1..C_KEY_WIDTH-1); low field width W_L = C_KEY_WIDTH-C_PREFIX_WIDTH, at most 32.
REQ-003 SHALL have parameter C_PREFIX, 16'h0101, value of the upper key field.
REQ-004 SHALL have parameter C_NUM_GEN, 5, keys per burst (1..255).
REQ-005 SHALL have parameter C_PAUSE, 3, idle cycles between bursts (0..255).
REQ-006 SHALL have parameter C_NUM_BURST, 0, bursts per run; 0 means unlimited.
REQ-007 SHALL have parameter C_LFSR_SEED, 32'h1, LFSR reset value; 0 is replaced by 1.
REQ-008 SHALL have ports:
- clk_i  in  1  single clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- strb_start_i  in  1  one-cycle run start.
- strb_stop_i  in  1  one-cycle run abort.
- mode_i  in  2  key mode: 0 random, 1 increment, 2 walking-one, 3 treated as 0.
- ready_i  in  1  sink accepts key.
- search_o  out  1  key valid.
- key_o  out  C_KEY_WIDTH  key: {C_PREFIX, low field}.
- busy_o  out  1  run active (state not IDLE).
- done_o  out  1  one-cycle pulse at normal run end.

Function
REQ-009 SHALL implement FSM states IDLE, BURST, PAUSE.
REQ-010 IDLE: strb_start_i (and not strb_stop_i) SHALL latch mode_i, clear burst/key/pause counters, load first key, and enter BURST; search_o=1 the next cycle.
REQ-011 A transfer SHALL occur when search_o && ready_i; key_o and search_o SHALL stay stable while search_o && !ready_i.
REQ-012 Each transfer SHALL load the next key in the same edge (back-to-back keys at full rate when ready_i=1).
REQ-013 Low field SHALL be: mode 0 = LFSR[W_L-1:0], LFSR advancing once per transfer; mode 1 = counter from 0, +1 per transfer, wrapping at 2^W_L-1 -> 0; mode 2 = one-hot starting at bit 0, rotating left per transfer, bit W_L-1 -> bit 0.
REQ-014 LFSR SHALL be 32-bit Galois, polynomial x^32+x^22+x^2+x+1, and SHALL NOT reset between runs.
REQ-015 After the C_NUM_GEN-th transfer of a burst: burst limit reached -> IDLE with done_o=1 for one cycle; else C_PAUSE>0 -> PAUSE with search_o=0 for exactly C_PAUSE cycles then BURST; else C_PAUSE=0 -> stay in BURST with search_o held 1.
REQ-016 strb_stop_i SHALL have priority over strb_start_i and every transition; in any state it SHALL force IDLE next cycle, search_o=0, done_o=0, and any unaccepted key is discarded.
REQ-017 strb_start_i outside IDLE SHALL be ignored.
REQ-018 mode_i changes during a run SHALL have no effect.
REQ-019 Burst counter SHALL be 8 bits; with C_NUM_BURST=0 it SHALL not terminate the run and may wrap.

Reset
REQ-020 rstn_i low SHALL immediately set state IDLE, search_o=0, key_o=0, busy_o=0, done_o=0, all counters 0, LFSR=C_LFSR_SEED (or 1).
REQ-021 Reset mid-burst SHALL abort with no done_o pulse; first start after release SHALL behave as REQ-010.

Configuration
REQ-022 With KEY_BURST_GEN_STAT_EN defined, SHALL add output key_cnt_o (32 bits) counting transfers since reset, saturating at 32'hFFFF_FFFF, unaffected by start/stop.
REQ-023 Without KEY_BURST_GEN_STAT_EN, key_cnt_o and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-024 Package key_gen_pkg SHALL hold the mode enum, state enum and LFSR polynomial constant.
REQ-025 LFSR SHALL be sub-module key_lfsr (seed parameter, enable input, 32-bit state output).

Verification
REQ-026 Defaults, mode 1, ready_i=1, C_NUM_BURST=2: start -> keys 0x010100..0x010104, 3 cycles search_o=0, keys 0x010105..0x010109, done_o pulse, busy_o=0.
REQ-027 Mode 1, ready_i low 4 cycles on 2nd key -> key_o holds 0x010101 for those cycles, no key skipped or duplicated.
REQ-028 Mode 2, W_L=8, 10 transfers -> low field 01,02,04..80,01,02.
REQ-029 C_PAUSE=0, C_NUM_BURST=3, mode 1 -> 15 consecutive keys, search_o never drops, done_o after 15th.
REQ-030 strb_stop_i and strb_start_i same cycle in IDLE -> stays IDLE; stop during PAUSE -> IDLE, no done_o; rstn_i low mid-burst -> all outputs 0 asynchronously.
REQ-031 KEY_BURST_GEN_STAT_EN defined, two runs of 5 keys -> key_cnt_o=10; mode 0 low field matches reference LFSR model from seed 1.

Source files
------------

// File: rtl/key_gen_pkg.sv
`default_nettype none
// ============================================================================
// key_gen_pkg : shared mode/state encodings and LFSR step for key_burst_gen
// Rev 1.0
// ============================================================================
package key_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RAND = 2'd0,
        MODE_INC  = 2'd1,
        MODE_WALK = 2'd2,
        MODE_RSVD = 2'd3
    } key_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_PAUSE = 2'd2
    } burst_state_e;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_lfsr.sv
`default_nettype none
// ============================================================================
// key_lfsr : 32-bit Galois LFSR, advances one step per enabled cycle
// Rev 1.0
// ============================================================================
module key_lfsr #(
    parameter logic [31:0] C_SEED = 32'h1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        en_i,
    output logic [31:0] state_o
);
    import key_gen_pkg::*;

    // An all-zero state would lock up the register
    localparam logic [31:0] SEED_EFF = (C_SEED == 32'h0) ? 32'h1 : C_SEED;

    logic [31:0] r_state;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= SEED_EFF;
        end else if (en_i) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: rtl/key_burst_gen.sv
`default_nettype none
// ============================================================================
// key_burst_gen : emits {prefix, low field} keys in bursts separated by pauses
//                 optional transfer counter via KEY_BURST_GEN_STAT_EN
// Rev 1.0
// ============================================================================
module key_burst_gen #(
    parameter int                        C_KEY_WIDTH    = 24,
    parameter int                        C_PREFIX_WIDTH = 16,
    parameter logic [C_PREFIX_WIDTH-1:0] C_PREFIX       = 16'h0101,
    parameter int                        C_NUM_GEN      = 5,
    parameter int                        C_PAUSE        = 3,
    parameter int                        C_NUM_BURST    = 0,
    parameter logic [31:0]               C_LFSR_SEED    = 32'h1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   strb_start_i,
    input  logic                   strb_stop_i,
    input  logic [1:0]             mode_i,
    input  logic                   ready_i,
    output logic                   search_o,
    output logic [C_KEY_WIDTH-1:0] key_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef KEY_BURST_GEN_STAT_EN
    ,
    output logic [31:0]            key_cnt_o
`endif
);
    import key_gen_pkg::*;

    localparam int         W_L           = C_KEY_WIDTH - C_PREFIX_WIDTH;
    localparam logic [7:0] GEN_LAST      = 8'(C_NUM_GEN - 1);
    localparam logic [7:0] PAUSE_LAST    = 8'(C_PAUSE - 1);
    localparam logic [7:0] BURST_LAST    = 8'(C_NUM_BURST - 1);
    localparam bit         BURST_LIMITED = (C_NUM_BURST != 0);
    localparam bit         HAS_PAUSE     = (C_PAUSE != 0);

    burst_state_e           r_state;
    key_mode_e              r_mode;
    logic                   r_search;
    logic                   r_done;
    logic [C_KEY_WIDTH-1:0] r_key;
    logic [7:0]             r_gen_cnt;
    logic [7:0]             r_burst_cnt;
    logic [7:0]             r_pause_cnt;

    logic [31:0]            w_lfsr;
    logic [31:0]            w_lfsr_next;
    logic [W_L-1:0]         w_low_cur;
    logic [W_L-1:0]         w_low_first;
    logic [W_L-1:0]         w_low_next;
    logic                   w_xfer;
    logic                   w_lfsr_en;
    key_mode_e              w_start_mode;

    assign w_xfer       = r_search & ready_i;
    assign w_lfsr_en    = w_xfer & (r_mode == MODE_RAND);
    assign w_lfsr_next  = lfsr_step(w_lfsr);
    assign w_low_cur    = r_key[W_L-1:0];
    assign w_start_mode = (mode_i == MODE_RSVD) ? MODE_RAND : key_mode_e'(mode_i);

    key_lfsr #(
        .C_SEED (C_LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (w_lfsr_en),
        .state_o (w_lfsr)
    );

    // Random keys show the LFSR state that will be current after the transfer
    always_comb begin
        w_low_first = W_L'(w_lfsr);
        w_low_next  = W_L'(w_lfsr_next);
        case (w_start_mode)
            MODE_INC:  w_low_first = '0;
            MODE_WALK: w_low_first = W_L'(1);
            default:   ;
        endcase
        case (r_mode)
            MODE_INC:  w_low_next = w_low_cur + W_L'(1);
            MODE_WALK: w_low_next = (w_low_cur << 1) | (w_low_cur >> (W_L - 1));
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_RAND;
            r_search    <= 1'b0;
            r_done      <= 1'b0;
            r_key       <= '0;
            r_gen_cnt   <= 8'd0;
            r_burst_cnt <= 8'd0;
            r_pause_cnt <= 8'd0;
        end else begin
            r_done <= 1'b0;
            if (strb_stop_i) begin
                r_state  <= ST_IDLE;
                r_search <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (strb_start_i) begin
                            r_mode      <= w_start_mode;
                            r_gen_cnt   <= 8'd0;
                            r_burst_cnt <= 8'd0;
                            r_pause_cnt <= 8'd0;
                            r_key       <= {C_PREFIX, w_low_first};
                            r_search    <= 1'b1;
                            r_state     <= ST_BURST;
                        end
                    end
                    ST_BURST: begin
                        if (w_xfer) begin
                            r_key <= {C_PREFIX, w_low_next};
                            if (r_gen_cnt == GEN_LAST) begin
                                r_gen_cnt   <= 8'd0;
                                r_burst_cnt <= r_burst_cnt + 8'd1;
                                if (BURST_LIMITED && (r_burst_cnt == BURST_LAST)) begin
                                    r_state  <= ST_IDLE;
                                    r_search <= 1'b0;
                                    r_done   <= 1'b1;
                                end else if (HAS_PAUSE) begin
                                    r_state     <= ST_PAUSE;
                                    r_search    <= 1'b0;
                                    r_pause_cnt <= 8'd0;
                                end
                            end else begin
                                r_gen_cnt <= r_gen_cnt + 8'd1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (r_pause_cnt == PAUSE_LAST) begin
                            r_pause_cnt <= 8'd0;
                            r_search    <= 1'b1;
                            r_state     <= ST_BURST;
                        end else begin
                            r_pause_cnt <= r_pause_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_search <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign search_o = r_search;
    assign key_o    = r_key;
    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = r_done;

`ifdef KEY_BURST_GEN_STAT_EN
    // Counts every handshake the sink saw, independent of run control
    logic [31:0] r_key_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_key_cnt <= 32'h0;
        end else if (w_xfer && (r_key_cnt != 32'hFFFF_FFFF)) begin
            r_key_cnt <= r_key_cnt + 32'd1;
        end
    end

    assign key_cnt_o = r_key_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_burst_gen.sv
`default_nettype none
// ============================================================================
// tb_key_burst_gen : directed self-checking bench for key_burst_gen
// Rev 1.0
// ============================================================================
module tb_key_burst_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        ready = 1'b1;

    logic        search_a, busy_a, done_a;
    logic [23:0] key_a;
    logic        search_b, busy_b, done_b;
    logic [23:0] key_b;
`ifdef KEY_BURST_GEN_STAT_EN
    logic [31:0] key_cnt_a, key_cnt_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Paused, two-burst configuration
    key_burst_gen #(.C_NUM_BURST(2)) dut_a (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .strb_start_i (start),
        .strb_stop_i  (stop),
        .mode_i       (mode),
        .ready_i      (ready),
        .search_o     (search_a),
        .key_o        (key_a),
        .busy_o       (busy_a),
        .done_o       (done_a)
`ifdef KEY_BURST_GEN_STAT_EN
        ,
        .key_cnt_o    (key_cnt_a)
`endif
    );

    // Pause-free, three-burst configuration
    key_burst_gen #(.C_PAUSE(0), .C_NUM_BURST(3)) dut_b (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .strb_start_i (start),
        .strb_stop_i  (stop),
        .mode_i       (mode),
        .ready_i      (ready),
        .search_o     (search_b),
        .key_o        (key_b),
        .busy_o       (busy_b),
        .done_o       (done_b)
`ifdef KEY_BURST_GEN_STAT_EN
        ,
        .key_cnt_o    (key_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return n;
    endfunction

    task automatic pulse_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        int          k;
        bit          seen_done;
        logic [31:0] m;
        logic [7:0]  walk;

        // Reset state
        #2 rstn = 1'b0;
        #1;
        check("rst_outputs", {search_a, busy_a, done_a, key_a}, 64'h0);
        step();
        step();
        rstn = 1'b1;
        step();

        // Two bursts of increment keys separated by a 3-cycle pause
        mode  = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'd2;
        check("r26_busy", busy_a, 1);
        for (int i = 0; i < 5; i++) begin
            check("r26_key_b1", {search_a, key_a}, {1'b1, 24'(24'h010100 + i)});
            step();
        end
        for (int p = 0; p < 3; p++) begin
            check("r26_pause", {busy_a, search_a}, 2'b10);
            step();
        end
        for (int i = 5; i < 10; i++) begin
            check("r26_key_b2", {search_a, key_a}, {1'b1, 24'(24'h010100 + i)});
            step();
        end
        check("r26_done", {done_a, busy_a, search_a}, 3'b100);
        step();
        check("r26_done_1cyc", done_a, 0);

        // Back-pressure on the second key
        mode  = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("r27_key0", key_a, 24'h010100);
        step();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("r27_hold", {search_a, key_a}, {1'b1, 24'h010101});
        end
        ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("r27_seq", {search_a, key_a}, {1'b1, 24'(24'h010100 + i)});
            step();
        end
        check("r30_in_pause", {busy_a, search_a}, 2'b10);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("r30_stop_pause", {busy_a, search_a, done_a}, 3'b000);
        step();
        check("r30_stop_nodone", done_a, 0);

        // Stop beats start in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("r30_stop_start", {busy_a, search_a}, 2'b00);

        // Walking one across both bursts
        mode  = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (search_a) begin
                walk = 8'h01 << (k % 8);
                check("r28_walk", key_a, {16'h0101, walk});
                k++;
            end
            if (done_a) seen_done = 1'b1;
            step();
        end
        check("r28_count", k, 10);
        check("r28_done_seen", seen_done, 1);

        // Pause-free run of three bursts
        pulse_reset();
        mode  = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("r29_key", {search_b, key_b}, {1'b1, 24'(24'h010100 + i)});
            step();
        end
        check("r29_done", {done_b, busy_b}, 2'b10);

        // Asynchronous reset mid-burst
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("r30_pre_rst", {busy_b, key_b}, {1'b1, 24'h010102});
        rstn = 1'b0;
        #1;
        check("r30_async_b", {search_b, busy_b, done_b, key_b}, 64'h0);
        check("r30_async_a", {search_a, busy_a, done_a, key_a}, 64'h0);
        step();
        rstn = 1'b1;
        step();
        check("r30_rst_nodone", done_b, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("r21_restart", {search_b, key_b}, {1'b1, 24'h010100});
        stop = 1'b1;
        step();
        stop = 1'b0;

        // Random keys against the reference LFSR from seed 1
        pulse_reset();
        mode  = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        m = 32'h1;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (search_a) begin
                check("r31_lfsr", key_a, {16'h0101, m[7:0]});
                m = lfsr_model(m);
                k++;
            end
            step();
        end
        check("r31_count", k, 10);
`ifdef KEY_BURST_GEN_STAT_EN
        check("r31_key_cnt", key_cnt_a, 32'd10);
`endif

        // Mode 3 behaves as random and continues the LFSR sequence
        mode  = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("r13_mode3", {search_a, key_a}, {1'b1, 16'h0101, m[7:0]});
        stop = 1'b1;
        step();
        stop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
